// File: rtl/maint_pkg.sv
// Shared types and helpers for the maintenance watchdog.
//   ch_state_t : per-channel FSM state
//   err_code   : all-ones error code for a given width (up to 64 bits)
package maint_pkg;

  typedef enum logic [1:0] {CH_IDLE, CH_ARMED, CH_ERROR} ch_state_t;

  function automatic logic [63:0] err_code(input int unsigned width);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maint_channel.sv
// One maintenance watchdog channel: rising-edge detector, IDLE/ARMED/ERROR
// FSM, inter-edge timer and saturating edge counter.
//   clk, rst  : clock, synchronous active-high reset
//   m_i       : maintenance request level
//   ack_i     : error acknowledge pulse
//   count_o   : accepted edge count (saturates at all-ones minus one)
//   error_o   : registered error flag
module maint_channel
  import maint_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             error_o
);

  localparam int unsigned      TW      = $clog2(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(err_code(WIDTH) - 64'd1);
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

  ch_state_t        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             m_prev_q;
  logic             error_q;
  logic             rise;

  assign rise = m_i & ~m_prev_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    unique case (state_q)
      CH_IDLE: begin
        timer_d = '0;
        count_d = '0;
        if (rise) begin
          state_d = CH_ARMED;
          count_d = WIDTH'(1);
        end
      end
      CH_ARMED: begin
        // An edge in the timeout cycle wins: it restarts the timer.
        if (rise) begin
          timer_d = '0;
          if (count_q != CNT_MAX) count_d = count_q + WIDTH'(1);
        end else if (timer_q == T_LAST) begin
          state_d = CH_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      CH_ERROR: begin
        // Edges are ignored here, including one coincident with ack.
        if (ack_i) begin
          state_d = CH_IDLE;
          timer_d = '0;
          count_d = '0;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CH_IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      m_prev_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      m_prev_q <= m_i;
      error_q  <= (state_d == CH_ERROR);
    end
  end

  assign count_o = count_q;
  assign error_o = error_q;

endmodule

// File: rtl/maint_monitor.sv
// Multi-channel maintenance watchdog top level.
//   clk, rst  : clock, synchronous active-high reset
//   m         : per-channel maintenance request levels
//   ack       : per-channel error acknowledge pulses
//   sel       : channel shown on status (out-of-range selects read 0)
//   status    : registered count of channel sel, all-ones if it is in error
//   error     : registered per-channel error flags
//   any_error : OR of error
module maint_monitor
  import maint_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned TIMEOUT  = 200,
  localparam int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] m,
  input  logic [CHANNELS-1:0] ack,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    status,
  output logic [CHANNELS-1:0] error,
  output logic                any_error
);

  localparam logic [WIDTH-1:0] ERR_CODE = WIDTH'(err_code(WIDTH));
  localparam logic [SELW:0]    SEL_LIM  = (SELW + 1)'(CHANNELS);

  logic [WIDTH-1:0]    count_w [CHANNELS];
  logic [CHANNELS-1:0] error_w;
  logic [WIDTH-1:0]    status_q, status_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    maint_channel #(
      .WIDTH  (WIDTH),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .m_i    (m[g]),
      .ack_i  (ack[g]),
      .count_o(count_w[g]),
      .error_o(error_w[g])
    );
  end

  always_comb begin
    status_d = '0;
    if ({1'b0, sel} < SEL_LIM) begin
      status_d = error_w[sel] ? ERR_CODE : count_w[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else     status_q <= status_d;
  end

  assign status    = status_q;
  assign error     = error_w;
  assign any_error = |error_w;

endmodule

// File: tb/tb_maint_monitor.sv
module tb_maint_monitor;

  localparam int CH  = 4;
  localparam int TO  = 200;
  localparam int MAX = 254;

  logic          clk;
  logic          rst;
  logic [CH-1:0] m;
  logic [CH-1:0] ack;
  logic [1:0]    sel;
  logic [7:0]    status;
  logic [CH-1:0] error;
  logic          any_error;

  maint_monitor #(
    .WIDTH   (8),
    .CHANNELS(CH),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m        (m),
    .ack      (ack),
    .sel      (sel),
    .status   (status),
    .error    (error),
    .any_error(any_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: channel mode 0=idle 1=armed 2=error, count, cycle of last accepted edge.
  int   mode  [CH];
  int   cnt   [CH];
  int   last  [CH];
  logic mprev [CH];
  int   cyc;
  int   st_exp;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic          rise;
    logic [CH-1:0] err_exp;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        mode[i] = 0; cnt[i] = 0; last[i] = 0; mprev[i] = 1'b0;
      end
      st_exp = 0;
    end else begin
      st_exp = (mode[sel] == 2) ? 255 : cnt[sel];
      for (int i = 0; i < CH; i++) begin
        rise     = m[i] & ~mprev[i];
        mprev[i] = m[i];
        case (mode[i])
          0: if (rise) begin
               mode[i] = 1; cnt[i] = 1; last[i] = cyc;
             end
          1: if (rise) begin
               if (cnt[i] < MAX) cnt[i]++;
               last[i] = cyc;
             end else if (cyc - last[i] >= TO) begin
               mode[i] = 2;
             end
          default: if (ack[i]) begin
               mode[i] = 0; cnt[i] = 0;
             end
        endcase
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < CH; i++) err_exp[i] = (mode[i] == 2);
    chk("status", 32'(status), 32'(st_exp));
    chk("error", 32'(error), 32'(err_exp));
    chk("any_error", 32'(any_error), 32'(|err_exp));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int ch);
    m[ch] = 1'b1;
    tick();
    m[ch] = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; st_exp = 0;
    for (int i = 0; i < CH; i++) begin
      mode[i] = 0; cnt[i] = 0; last[i] = 0; mprev[i] = 1'b0;
    end
    rst = 1'b1; m = '0; ack = '0; sel = 2'd0;

    // Reset state, then a long quiet period must not time out.
    tick(); tick();
    chk("lit_rst_status", 32'(status), 32'h00);
    chk("lit_rst_error", 32'(error), 32'h0);
    chk("lit_rst_any", 32'(any_error), 32'h0);
    rst = 1'b0;
    idle(500);
    chk("lit_idle_error", 32'(error), 32'h0);

    // Channel 0: five pulses, 50 cycles apart.
    sel = 2'd0;
    repeat (5) begin
      pulse(0);
      idle(49);
    end
    chk("lit_ch0_count5", 32'(status), 32'h05);
    chk("lit_ch0_noerr", 32'(error[0]), 32'h0);

    // Channel 1: single pulse then silence -> error one cycle after deadline.
    sel = 2'd1;
    pulse(1);
    idle(199);
    chk("lit_ch1_before_to", 32'(error[1]), 32'h0);
    tick();
    chk("lit_ch1_err", 32'(error[1]), 32'h1);
    chk("lit_ch1_any", 32'(any_error), 32'h1);
    tick();
    chk("lit_ch1_status_ff", 32'(status), 32'hFF);
    ack[1] = 1'b1; tick(); ack[1] = 1'b0;
    chk("lit_ch1_acked", 32'(error[1]), 32'h0);

    // Channel 1: second edge lands in the timeout cycle and wins.
    pulse(1);
    idle(199);
    pulse(1);
    tick();
    chk("lit_ch1_edge_wins", 32'(error[1]), 32'h0);
    chk("lit_ch1_count2", 32'(status), 32'h02);

    // Channel 2: 300 pulses every 4 cycles saturate at FE.
    sel = 2'd2;
    repeat (300) begin
      pulse(2);
      idle(3);
    end
    chk("lit_ch2_sat", 32'(status), 32'hFE);
    chk("lit_ch2_noerr", 32'(error[2]), 32'h0);
    ack[2] = 1'b1; tick(); ack[2] = 1'b0;
    tick();
    chk("lit_ch2_ack_ignored", 32'(status), 32'hFE);

    // Channel 3: ack and edge together in ERROR -> idle, edge not counted.
    sel = 2'd3;
    pulse(3);
    idle(201);
    chk("lit_ch3_err", 32'(error[3]), 32'h1);
    m[3] = 1'b1; ack[3] = 1'b1;
    tick();
    m[3] = 1'b0; ack[3] = 1'b0;
    tick();
    chk("lit_ch3_idle_status", 32'(status), 32'h00);
    chk("lit_ch3_idle_err", 32'(error[3]), 32'h0);
    pulse(3);
    tick();
    chk("lit_ch3_rearm", 32'(status), 32'h01);

    // Reset mid-activity: ch1 in error, ch0 counting, m[2] held through reset.
    sel = 2'd0;
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    pulse(0);
    idle(3);
    chk("lit_pre_rst_ch1_err", 32'(error[1]), 32'h1);
    m[2] = 1'b1;
    rst = 1'b1;
    tick();
    chk("lit_post_rst_status", 32'(status), 32'h00);
    chk("lit_post_rst_error", 32'(error), 32'h0);
    chk("lit_post_rst_any", 32'(any_error), 32'h0);
    rst = 1'b0;
    sel = 2'd2;
    tick(); tick();
    chk("lit_held_m_edge", 32'(status), 32'h01);
    m[2] = 1'b0;
    sel = 2'd1;
    pulse(1);
    tick();
    chk("lit_ch1_restart", 32'(status), 32'h01);
    chk("lit_ch1_restart_err", 32'(error[1]), 32'h0);
    sel = 2'd0;
    pulse(0);
    tick();
    chk("lit_ch0_restart", 32'(status), 32'h01);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/maint_monitor.md
# maint_monitor

Parametrised, multi-channel maintenance watchdog. Each channel counts rising edges of its maintenance request and requires the next one within a programmable timeout; a missed deadline latches a per-channel error until acknowledged. A registered status port returns the selected channel's count, or all-ones when that channel is in error. It sits between the maintenance request sources and the status/diagnostic register path.

## Interface
- `WIDTH`, 8: count and status width; all-ones is reserved as the error code.
- `CHANNELS`, 4: number of independent maintenance channels, ≥1.
- `TIMEOUT`, 200: cycles allowed between consecutive request edges, ≥2.
- `SELW`, derived `$clog2(CHANNELS)` (min 1): select width.
- `TW`, derived `$clog2(TIMEOUT)`: timer width.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m`  in  CHANNELS  maintenance request level, bit i = channel i.
- `ack`  in  CHANNELS  error acknowledge, bit i = channel i, single-cycle pulse.
- `sel`  in  SELW  channel shown on `status`; values ≥ CHANNELS read as 0.
- `status`  out  WIDTH  registered count of channel `sel`, or all-ones if it is in error.
- `error`  out  CHANNELS  registered per-channel error flag.
- `any_error`  out  1  OR of `error`.

## Operation
- Edge detect per channel: `m_prev` register; edge = `m & ~m_prev`. `m_prev` resets to 0, so `m` held high through reset counts as one edge on the first cycle after reset.
- Per-channel FSM:
  - IDLE: timer stopped at 0, count 0. Edge → ARMED, count = 1, timer = 0.
  - ARMED: timer increments each cycle.
    - Edge → stay ARMED, count + 1, timer = 0.
    - No edge while timer == TIMEOUT−1 → ERROR.
  - ERROR: count and timer frozen; edges ignored. `ack` → IDLE, count = 0, timer = 0.
- Count saturates at all-ones−1 (8'hFE for WIDTH=8). Further edges still restart the timer.
- Boundary conditions:
  - Edge and timeout in the same cycle: the edge wins and the channel stays ARMED.
  - `ack` outside ERROR is ignored.
  - `ack` and edge in the same ERROR cycle: go to IDLE; that edge is not counted, and the next fresh edge re-arms.
- Outputs:
  - `error[i]` = (state == ERROR).
  - `status` <= error[sel] ? all-ones : count[sel].
  - `any_error` is combinational OR of the `error` registers.
- Reset: all channels IDLE, counts 0, timers 0, `m_prev` 0, `status` 0, `error` 0, `any_error` 0. Reset in any state, including mid-timeout or ERROR, returns to these values on the next edge with no residue.

## Timing
- Edge sampled in cycle t (m[i]=1 at t, 0 at t−1): count updates at t+1; `status` reflects it at t+2 when `sel`=i.
- `sel` change → `status` updates one cycle later.
- Last accepted edge at cycle t, no further edge: timer reads k−1 at t+k, and `error[i]` rises at t+TIMEOUT+1. An edge sampled at t+TIMEOUT, or earlier, prevents the error.
- `ack` at cycle t → `error[i]` low at t+1; `status` shows 0 at t+2.
- Channels are fully independent; any number may change state in the same cycle.

## Structure
- Package `maint_pkg` contains:
  - `typedef enum logic [1:0] {CH_IDLE, CH_ARMED, CH_ERROR} ch_state_t`.
  - A function returning the all-ones error code for a given width.
- Sub-module `maint_channel` holds the edge detector, FSM, timer and saturating counter for one channel; parameters WIDTH and TIMEOUT; outputs count and error.
- The top level generates CHANNELS instances, plus the status mux/register and the any_error OR.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, TIMEOUT=200.
- Reset with `m`=0 → status=8'h00, error=4'b0000, any_error=0. Hold 500 cycles → no error, since IDLE channels never time out.
- Channel 0, 5 single-cycle pulses every 50 cycles, sel=0 → status=8'h05, error[0]=0.
- Channel 1, one pulse at t, then silence → error[1]=1 at t+201, any_error=1, status(sel=1)=8'hFF. A second run with a pulse at t+200 → no error, count=2.
- Channel 2, 300 pulses every 4 cycles → status=8'hFE, never 8'hFF; error[2]=0.
- Channel 3 in ERROR, `ack[3]` and `m[3]` edge in the same cycle → IDLE, status=8'h00. The next pulse gives status=8'h01 and the channel ARMED.
- Channel 1 in error and channel 0 counting, rst pulsed for one cycle → all outputs 0 next cycle; channels restart independently.
